// File: rtl/av_palette_loader.sv
// av_palette_loader
// Captures a 16-byte GBP palette file from the HPS download channel into a
// shadow buffer, checks that every byte slot was written, and commits the
// foreground/background colours atomically on the next vblank rising edge.
//
// Ports:
//   clk_sys     system clock, all logic on its rising edge
//   reset       asynchronous active-high reset
//   dl_active   palette download in progress
//   dl_wr       one-cycle byte strobe
//   dl_addr     byte offset within the file
//   dl_data     byte value
//   vblank      vertical blank, synchronous to clk_sys
//   color_fg    committed foreground RGB {R,G,B} (shadow bytes 0..2)
//   color_bg    committed background RGB {R,G,B} (shadow bytes 9..11)
//   pal_loaded  sticky, set by the first successful commit
//   busy        high while loading or waiting for vblank
//   err         last download ended with unwritten bytes
module av_palette_loader #(
    parameter logic [23:0] DEF_FG = 24'h828214,
    parameter logic [23:0] DEF_BG = 24'h1A3B49
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic        vblank,
    output logic [23:0] color_fg,
    output logic [23:0] color_bg,
    output logic        pal_loaded,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PENDING
    } state_t;

    state_t      state, state_next;
    logic        dl_active_d, vblank_d;
    logic [7:0]  shadow [16];
    logic [15:0] mask, mask_next;
    logic        err_next;
    logic        commit;
    logic        dl_rise, dl_fall, vb_rise;
    logic        byte_hit;
    logic [3:0]  byte_idx;

    assign dl_rise  = dl_active & ~dl_active_d;
    assign dl_fall  = ~dl_active & dl_active_d;
    assign vb_rise  = vblank & ~vblank_d;
    assign byte_hit = dl_wr & dl_active & (dl_addr < 25'd16);
    assign byte_idx = dl_addr[3:0];
    assign busy     = (state != ST_IDLE);

    // Byte writes are gated only by dl_active, so a strobe in the same cycle
    // as the dl_active rise lands in the freshly cleared mask.
    always_comb begin
        state_next = state;
        mask_next  = mask;
        err_next   = err;
        commit     = 1'b0;
        if (dl_rise) begin
            // A new download abandons any pending commit.
            mask_next  = '0;
            err_next   = 1'b0;
            state_next = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (dl_fall) begin
                        if (mask == 16'hFFFF) begin
                            state_next = ST_PENDING;
                        end else begin
                            err_next   = 1'b1;
                            state_next = ST_IDLE;
                        end
                    end
                end
                ST_PENDING: begin
                    if (vb_rise) begin
                        commit     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
        if (byte_hit) begin
            mask_next[byte_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            mask        <= '0;
            err         <= 1'b0;
            dl_active_d <= 1'b0;
            vblank_d    <= 1'b0;
            color_fg    <= DEF_FG;
            color_bg    <= DEF_BG;
            pal_loaded  <= 1'b0;
        end else begin
            state       <= state_next;
            mask        <= mask_next;
            err         <= err_next;
            dl_active_d <= dl_active;
            vblank_d    <= vblank;
            if (commit) begin
                color_fg   <= {shadow[0], shadow[1], shadow[2]};
                color_bg   <= {shadow[9], shadow[10], shadow[11]};
                pal_loaded <= 1'b1;
            end
        end
    end

    // Shadow contents need no reset: the mask decides whether they are used.
    always_ff @(posedge clk_sys) begin
        if (byte_hit) begin
            shadow[byte_idx] <= dl_data;
        end
    end

endmodule

// File: tb/tb_av_palette_loader.sv
// tb_av_palette_loader
// Self-checking bench for av_palette_loader: directed scenarios plus
// randomized downloads compared against a file-level reference model.
module tb_av_palette_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_active;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        vblank;
    logic [23:0] color_fg;
    logic [23:0] color_bg;
    logic        pal_loaded;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model: file contents, which slots were written, and the
    // user-visible status.
    logic [7:0]  m_shadow [16];
    bit          m_written [16];
    logic [23:0] m_fg, m_bg, m_pfg, m_pbg;
    bit          m_loaded, m_err, m_loading, m_pending;

    always #5 clk_sys = ~clk_sys;

    av_palette_loader #(
        .DEF_FG(24'h828214),
        .DEF_BG(24'h1A3B49)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .dl_active (dl_active),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .vblank    (vblank),
        .color_fg  (color_fg),
        .color_bg  (color_bg),
        .pal_loaded(pal_loaded),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_fg"}, 32'(color_fg), 32'(m_fg));
        check({tag, "_bg"}, 32'(color_bg), 32'(m_bg));
        check({tag, "_loaded"}, 32'(pal_loaded), 32'(m_loaded));
        check({tag, "_busy"}, 32'(busy), 32'(m_loading | m_pending));
        check({tag, "_err"}, 32'(err), 32'(m_err));
    endtask

    task automatic model_reset();
        m_fg      = 24'h828214;
        m_bg      = 24'h1A3B49;
        m_loaded  = 0;
        m_err     = 0;
        m_loading = 0;
        m_pending = 0;
        for (int i = 0; i < 16; i++) m_written[i] = 0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        dl_active = 1'b0;
        dl_wr     = 1'b0;
        vblank    = 1'b0;
        #3;
        model_reset();
        check_all("in_reset");
        tick();
        reset = 1'b0;
        tick();
        check_all("post_reset");
    endtask

    task automatic start_dl();
        dl_active = 1'b1;
        tick();
        m_loading = 1;
        m_pending = 0;
        m_err     = 0;
        for (int i = 0; i < 16; i++) m_written[i] = 0;
    endtask

    task automatic put(input logic [24:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick();
        dl_wr = 1'b0;
        if (dl_active && a < 25'd16) begin
            m_shadow[a[3:0]]  = d;
            m_written[a[3:0]] = 1;
        end
    endtask

    task automatic end_dl(input bit with_vb);
        bit complete;
        dl_active = 1'b0;
        vblank    = with_vb;
        tick();
        complete = 1;
        for (int i = 0; i < 16; i++) if (!m_written[i]) complete = 0;
        m_loading = 0;
        if (complete) begin
            m_pending = 1;
            m_pfg = {m_shadow[0], m_shadow[1], m_shadow[2]};
            m_pbg = {m_shadow[9], m_shadow[10], m_shadow[11]};
        end else begin
            m_err = 1;
        end
        check_all("end_dl");
        if (with_vb) begin
            // vblank already high when waiting starts: no commit until it re-rises
            tick();
            check_all("vb_held");
            vblank = 1'b0;
            tick();
            check_all("vb_dropped");
        end
    endtask

    task automatic vb_pulse();
        check_all("pre_vb");
        vblank = 1'b1;
        tick();
        if (m_pending) begin
            m_fg      = m_pfg;
            m_bg      = m_pbg;
            m_loaded  = 1;
            m_pending = 0;
        end
        check_all("vb_rise");
        vblank = 1'b0;
        tick();
        check_all("vb_low");
    endtask

    initial begin
        dl_addr = '0;
        dl_data = '0;
        for (int i = 0; i < 16; i++) m_shadow[i] = '0;

        // Reset state
        do_reset();

        // Full file 00..0F
        start_dl();
        for (int i = 0; i < 16; i++) put(25'(i), 8'(i));
        end_dl(0);
        vb_pulse();
        check("plan_fg", 32'(color_fg), 32'h000102);
        check("plan_bg", 32'(color_bg), 32'h090A0B);

        // Short file of 10 bytes
        do_reset();
        start_dl();
        for (int i = 0; i < 10; i++) put(25'(i), 8'(8'h40 + i));
        end_dl(0);
        check("short_err", 32'(err), 32'h1);
        vb_pulse();
        check("short_fg", 32'(color_fg), 32'h828214);

        // Rewritten byte 0 and trailing bytes beyond the palette
        start_dl();
        put(25'd0, 8'hAA);
        for (int i = 1; i < 16; i++) put(25'(i), 8'(i));
        put(25'd0, 8'h55);
        for (int i = 16; i < 20; i++) put(25'(i), 8'hFF);
        end_dl(0);
        vb_pulse();
        check("dup_fg", 32'(color_fg), 32'h550102);
        check("dup_bg", 32'(color_bg), 32'h090A0B);

        // Restart before vblank abandons the first file
        start_dl();
        for (int i = 0; i < 16; i++) put(25'(i), 8'hC0);
        end_dl(0);
        start_dl();
        put(25'd0, 8'h11);
        put(25'd1, 8'h22);
        put(25'd2, 8'h33);
        for (int i = 3; i < 16; i++) put(25'(i), 8'h07);
        end_dl(0);
        vb_pulse();
        check("restart_fg", 32'(color_fg), 32'h112233);

        // Reset in the middle of a load
        do_reset();
        start_dl();
        for (int i = 0; i < 8; i++) put(25'(i), 8'h99);
        do_reset();
        vb_pulse();

        // vblank rising together with the end of download
        start_dl();
        for (int i = 0; i < 16; i++) put(25'(i), 8'(8'hE0 + i));
        end_dl(1);
        vb_pulse();
        check("coinc_fg", 32'(color_fg), 32'hE0E1E2);

        // Randomized downloads
        for (int it = 0; it < 40; it++) begin
            int n;
            start_dl();
            n = $urandom_range(4, 24);
            for (int k = 0; k < n; k++) begin
                logic [24:0] a;
                if ($urandom_range(0, 5) == 0) a = 25'($urandom_range(16, 33554431));
                else a = 25'($urandom_range(0, 15));
                put(a, 8'($urandom));
                if ($urandom_range(0, 3) == 0) tick();
            end
            if ($urandom_range(0, 3) != 0) begin
                for (int i = 0; i < 16; i++) if (!m_written[i]) put(25'(i), 8'($urandom));
            end
            end_dl($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) put(25'($urandom_range(0, 11)), 8'($urandom));
            if ($urandom_range(0, 4) != 0) vb_pulse();
        end
        vb_pulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/av_palette_loader.md
# av_palette_loader

Captures a custom 16-byte GBP palette file streamed from the HPS download channel into a shadow buffer. It validates that the file is complete and commits the foreground and background colours atomically at the next vertical-blank rising edge, so a palette change never tears mid-frame. It sits between the hps_io download port and the palette mux that drives the video mixer RGB inputs. It replaces a free-running shift register with a length-checked, frame-synchronised load.

## Interface
Parameters:
- DEF_FG, 24'h828214, foreground colour after reset.
- DEF_BG, 24'h1A3B49, background colour after reset.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- dl_active  in  1  palette download in progress (ioctl_download qualified by palette index).
- dl_wr  in  1  one-cycle byte strobe.
- dl_addr  in  25  byte offset within the file.
- dl_data  in  8  byte value.
- vblank  in  1  video vertical blank, synchronous to clk_sys.
- color_fg  out  24  committed foreground RGB, {R,G,B}.
- color_bg  out  24  committed background RGB.
- pal_loaded  out  1  sticky; set by the first successful commit.
- busy  out  1  high in LOAD or PENDING.
- err  out  1  last download ended incomplete.

## Operation
- Shadow buffer: 16 x 8 bit, plus a 16-bit written mask.
- Byte placement: on dl_wr & dl_active with dl_addr < 16, write shadow[dl_addr] and set mask[dl_addr].
  - Writes with dl_addr >= 16 are ignored; longer files are accepted.
  - A repeated address overwrites the earlier value; last write wins.
  - dl_wr while dl_active is low is ignored.
- Colour extraction:
  - Foreground = shadow bytes 0,1,2 as R,G,B.
  - Background = shadow bytes 9,10,11 as R,G,B.
  - All other bytes are stored but unused.
- State machine (registered dl_active_d and vblank_d provide edge detection):
  - IDLE: on dl_active rise, clear mask, clear err, go to LOAD.
  - LOAD: accept bytes. On dl_active fall:
    - mask == 16'hFFFF → PENDING.
    - otherwise → set err, go to IDLE; committed colours unchanged.
  - PENDING: on vblank rise (vblank & ~vblank_d), load color_fg/color_bg from shadow, set pal_loaded, go to IDLE.
  - PENDING with dl_active rise: abandon the pending commit, clear mask and err, go to LOAD.
- dl_active rise has priority over vblank rise in the same cycle.
- Reset: state IDLE, mask 0, color_fg = DEF_FG, color_bg = DEF_BG, pal_loaded 0, busy 0, err 0, edge registers 0. Shadow contents are don't-care.
- Reset asserted mid-load discards the load entirely.

## Timing
- Byte write latency: shadow updated at the edge sampling dl_wr; no back-pressure (ioctl_wait held 0).
- Download end:
  - The edge sampling dl_active = 0 (with dl_active_d = 1) moves the state to PENDING or IDLE.
  - err becomes visible the following cycle.
- Commit: outputs change at the edge where vblank = 1 and vblank_d = 0; new colours are visible one cycle after vblank is first sampled high.
- A vblank rise in the same cycle as the dl_active fall does not commit; the commit waits for the next vblank rise.
- If vblank is already high when PENDING is entered, there is no commit until vblank falls and rises again.
- busy is high from the cycle after the dl_active rise until the cycle after the commit or error.
- color_fg/color_bg are registers, glitch-free, and change only on commit or reset.

## Test plan
- Reset → color_fg = 828214, color_bg = 1A3B49, pal_loaded = 0, busy = 0, err = 0.
- Stream 16 bytes 00..0F, then end the download, then pulse vblank → colours unchanged before the vblank rise; one cycle after it, color_fg = 000102, color_bg = 090A0B, pal_loaded = 1, busy = 0.
- Stream only 10 bytes, then end the download → err = 1, busy = 0, colours still 828214/1A3B49; a following vblank rise changes nothing.
- Stream 20 bytes where byte 0 is written twice (AA, then 55) and bytes 16..19 are FF → after commit, color_fg[23:16] = 55; extra bytes have no effect.
- Complete a 16-byte load, then restart the download before any vblank rise with a new file (fg = 112233) → the first file is never committed; after the second ends and vblank rises, color_fg = 112233.
- Assert reset during LOAD after 8 bytes, release, then pulse vblank → defaults held, busy = 0, pal_loaded = 0, err = 0.
